// File: rtl/speech256_pkg.sv
// Shared Speech256 definitions: allophone width, pause codes and the
// queue handshake state encoding.
package speech256_pkg;

  localparam int ALLO_W = 6;

  localparam logic [ALLO_W-1:0] PA1 = 6'd0;
  localparam logic [ALLO_W-1:0] PA2 = 6'd1;
  localparam logic [ALLO_W-1:0] PA3 = 6'd2;
  localparam logic [ALLO_W-1:0] PA4 = 6'd3;
  localparam logic [ALLO_W-1:0] PA5 = 6'd4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STROBE  = 2'd1,
    WAIT_LO = 2'd2
  } q_state_t;

endpackage

// File: rtl/speech_sync_fifo.sv
// Single-clock FIFO with registered occupancy count; full/empty decode from
// the count, so a push into a full queue is refused even if a pop coincides.
module speech_sync_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int WIDTH      = 6
) (
  input  logic                  clk,
  input  logic                  rst_an,
  input  logic                  clr,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      wr_data,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  push_ok;
  logic                  pop_ok;

  assign full    = (level == (DEPTH_LOG2 + 1)'(DEPTH));
  assign empty   = (level == '0);
  assign push_ok = push && !full && !clr;
  assign pop_ok  = pop && !empty && !clr;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/allophone_queue.sv
// Allophone queue feeding the Speech256 core: FIFO plus an ldq handshake FSM
// that strobes one code at a time and waits for ldq to drop before the next.
module allophone_queue
  import speech256_pkg::*;
#(
  parameter int DEPTH_LOG2  = 4,
  parameter int ALLO_W      = speech256_pkg::ALLO_W,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst_an,
  input  logic [ALLO_W-1:0]    wr_data,
  input  logic                 wr_stb,
  input  logic                 flush,
  output logic                 full,
  output logic                 empty,
  output logic [DEPTH_LOG2:0]  level,
  output logic                 overflow,
  output logic                 ack_err,
  input  logic                 ldq,
  output logic [ALLO_W-1:0]    data_out,
  output logic                 data_stb,
  output logic                 busy
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TW-1:0] T_LAST = TW'(ACK_TIMEOUT - 1);

  q_state_t          state;
  q_state_t          next_state;
  logic [TW-1:0]     timer;
  logic              pop;
  logic              timeout;
  logic [ALLO_W-1:0] head;

  speech_sync_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WIDTH      (ALLO_W)
  ) u_fifo (
    .clk     (clk),
    .rst_an  (rst_an),
    .clr     (flush),
    .push    (wr_stb),
    .pop     (pop),
    .wr_data (wr_data),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );

  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an) state <= IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (flush) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:    if (!empty && ldq) next_state = STROBE;
        STROBE:  next_state = WAIT_LO;
        WAIT_LO: if (!ldq || timer == T_LAST) next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  always_comb begin
    pop      = 1'b0;
    timeout  = 1'b0;
    data_stb = (state == STROBE);
    if (!flush) begin
      pop     = (state == IDLE) && !empty && ldq;
      timeout = (state == WAIT_LO) && ldq && (timer == T_LAST);
    end
  end

  assign busy = !(empty && state == IDLE);

  // Timer counts WAIT_LO cycles; flags are sticky until flush or reset.
  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an) begin
      timer    <= '0;
      overflow <= 1'b0;
      ack_err  <= 1'b0;
      data_out <= '0;
    end else begin
      timer <= (state == WAIT_LO) ? timer + 1'b1 : '0;
      if (flush) begin
        overflow <= 1'b0;
        ack_err  <= 1'b0;
      end else begin
        if (wr_stb && full) overflow <= 1'b1;
        if (timeout)        ack_err  <= 1'b1;
        if (pop)            data_out <= head;
      end
    end
  end

endmodule
